fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch unit with credit-limited prefetch FIFO
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            cpu_rstn,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_rd_addr,
   input  logic [XLEN-1:0] mem_rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            out_misaligned
);
   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
   state_t state_q, state_d;

   logic [XLEN-1:0] pc_q;
   logic            inflight_q;
   logic [XLEN-1:0] inflight_pc_q;
   logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            credit_ok, trap, trap_cond, pop, push, rsp_push;
   logic [XLEN-1:0] push_instr, push_pc, redirect_tgt, reset_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fifo_mis [FIFO_DEPTH];

   assign redirect_tgt   = redirect_pc;
   assign reset_tgt      = RESET_PC;
   assign mem_rd_addr    = pc_q;
   assign trap_cond      = (pc_q[1:0] != 2'b00);
   assign out_misaligned = fifo_mis[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push && cpu_rstn) fifo_mis[wr_ptr_q] <= trap;
   end
`else
   logic unused_low_bits;

   assign redirect_tgt    = {redirect_pc[XLEN-1:2], 2'b00};
   assign reset_tgt       = {RESET_PC[XLEN-1:2], 2'b00};
   assign mem_rd_addr     = {pc_q[XLEN-1:2], 2'b00};
   assign trap_cond       = 1'b0;
   assign out_misaligned  = 1'b0;
   assign unused_low_bits = ^{redirect_pc[1:0], pc_q[1:0]};
`endif

   // In-flight request reserves a FIFO slot so the response always has room.
   assign credit_ok = (count_q + CW'(inflight_q)) < DEPTH_C;
   assign out_valid = (count_q != '0);
   assign out_instr = fifo_instr[rd_ptr_q];
   assign out_pc    = fifo_pc[rd_ptr_q];
   assign pop       = out_valid && out_ready;

   // A redirect discards whatever response lands in its own cycle.
   assign rsp_push   = inflight_q && !redirect_valid;
   assign push       = rsp_push || trap;
   assign push_instr = trap ? '0 : mem_rd_data;
   assign push_pc    = trap ? pc_q : inflight_pc_q;
   assign count_d    = count_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (!cpu_rstn) state_q <= RUN;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) state_d = RUN;
      else if (trap)      state_d = HALT;
   end

   // Trap waits for an empty in-flight slot so it never collides with a response push.
   always_comb begin
      mem_req = 1'b0;
      trap    = 1'b0;
      if (cpu_rstn && state_q == RUN && !redirect_valid && credit_ok) begin
         if (trap_cond) trap    = !inflight_q;
         else           mem_req = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!cpu_rstn) begin
         pc_q          <= reset_tgt;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         inflight_q    <= mem_req;
         inflight_pc_q <= mem_rd_addr;
         if (redirect_valid) begin
            pc_q     <= redirect_tgt;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (mem_req) pc_q <= pc_q + XLEN'(4);
            if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && cpu_rstn) begin
         fifo_instr[wr_ptr_q] <= push_instr;
         fifo_pc[wr_ptr_q]    <= push_pc;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scenario bench for fetch_unit against a stream-level fetch model
// Misalignment scenario follows FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clk = 1'b0;
   logic        cpu_rstn = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_misaligned;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .cpu_rstn(cpu_rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_misaligned(out_misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Synchronous instruction memory: data one cycle after the strobe.
   always @(posedge clk) if (mem_req) mem_rd_data <= mem_word(mem_rd_addr);

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      cpu_rstn = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
      step(); step();
      cpu_rstn = 1'b1;
   endtask

   task automatic test_reset();
      cpu_rstn = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
      redirect_valid = 1'b0;
      do_reset();
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== RPC) begin n_fail++; $display("FAIL reset_first_req req=%0b addr=%h want 1/%h", mem_req, mem_rd_addr, RPC); end
   endtask

   task automatic test_stream();
      do_reset(); out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== RPC + 32'(4 * k)) begin n_fail++; $display("FAIL stream_req c%0d req=%0b addr=%h want 1/%h", k, mem_req, mem_rd_addr, RPC + 32'(4 * k)); end
         if (k < 2) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c%0d got %0b want 0", k, out_valid); end
         end else begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== RPC + 32'(4 * (k - 2)) || out_instr !== mem_word(RPC + 32'(4 * (k - 2)))) begin
               n_fail++; $display("FAIL stream_out c%0d v=%0b pc=%h instr=%h want pc %h", k, out_valid, out_pc, out_instr, RPC + 32'(4 * (k - 2)));
            end
         end
         step();
      end
   endtask

   task automatic test_stall();
      int nreq = 0, viol = 0, ndel = 0;
      logic [31:0] exp;
      do_reset(); out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req) nreq++;
         if (i >= 2 && (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== mem_word(RPC))) viol++;
         step();
      end
      n_tests++; if (nreq != DEPTH) begin n_fail++; $display("FAIL stall_req_count got %0d want %0d", nreq, DEPTH); end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", viol); end
      out_ready = 1'b1;
      exp = RPC;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (out_valid) begin
            n_tests++; if (out_pc !== exp || out_instr !== mem_word(exp)) begin n_fail++; $display("FAIL stall_drain pc=%h instr=%h want %h", out_pc, out_instr, exp); end
            exp += 32'd4; ndel++;
         end
         step();
      end
      n_tests++; if (ndel < DEPTH + 2) begin n_fail++; $display("FAIL stall_drain_count got %0d want >=%0d", ndel, DEPTH + 2); end
   endtask

   task automatic test_redirect_inflight();
      logic [31:0] exp;
      int ndel = 0;
      do_reset(); out_ready = 1'b0;
      repeat (4) step();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL redir_cycle v=%0b req=%0b want 1/0", out_valid, mem_req); end
      step(); redirect_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== 32'h100) begin n_fail++; $display("FAIL redir_first_req req=%0b addr=%h want 1/100", mem_req, mem_rd_addr); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %0b want 0", out_valid); end
      exp = 32'h100;
      for (int i = 0; i < 10; i++) begin
         step(); @(negedge clk);
         if (out_valid) begin
            n_tests++; if (out_pc !== exp || out_instr !== mem_word(exp)) begin n_fail++; $display("FAIL redir_stream pc=%h want %h", out_pc, exp); end
            exp += 32'd4; ndel++;
         end
      end
      n_tests++; if (ndel == 0) begin n_fail++; $display("FAIL redir_no_delivery got 0 want >0"); end
   endtask

   task automatic test_redirect_on_transfer();
      logic [31:0] exp, tgt;
      int n8 = 0, nafter = 0;
      tgt = {18'd0, 12'($urandom_range(64, 4000)), 2'b00};
      do_reset(); out_ready = 1'b1; exp = RPC;
      for (int c = 0; c < 14; c++) begin
         redirect_valid = (c == 4); redirect_pc = tgt;
         @(negedge clk);
         if (out_valid) begin
            n_tests++; if (out_pc !== exp || out_instr !== mem_word(exp)) begin n_fail++; $display("FAIL xfer_redir_seq c%0d pc=%h want %h", c, out_pc, exp); end
            if (out_pc == 32'h8) n8++;
            if (c > 4) nafter++;
            exp += 32'd4;
         end
         if (c == 4) exp = tgt;
         step();
      end
      redirect_valid = 1'b0;
      n_tests++; if (n8 != 1) begin n_fail++; $display("FAIL xfer_redir_once got %0d want 1", n8); end
      n_tests++; if (nafter == 0) begin n_fail++; $display("FAIL xfer_redir_target got 0 deliveries want >0"); end
   endtask

   task automatic test_reset_midstream();
      do_reset(); out_ready = 1'b0;
      repeat (8) step();
      cpu_rstn = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_req got %0b want 0", mem_req); end
      step(); cpu_rstn = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %0b want 0", out_valid); end
      n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== RPC) begin n_fail++; $display("FAIL midreset_restart req=%0b addr=%h want 1/%h", mem_req, mem_rd_addr, RPC); end
      step(); step(); @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== mem_word(RPC)) begin n_fail++; $display("FAIL midreset_first_out v=%0b pc=%h want 1/%h", out_valid, out_pc, RPC); end
      step();
   endtask

   task automatic test_misalign();
`ifdef FETCH_MISALIGN_TRAP_EN
      int nreq = 0, ntrap = 0;
      do_reset(); out_ready = 1'b1;
      repeat (3) step();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      step(); redirect_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mem_req) nreq++;
         if (out_valid && out_misaligned && out_pc == 32'h102 && out_instr == 32'h0) ntrap++;
         step();
      end
      n_tests++; if (nreq != 0) begin n_fail++; $display("FAIL trap_halt_req got %0d want 0", nreq); end
      n_tests++; if (ntrap != 1) begin n_fail++; $display("FAIL trap_entry got %0d want 1", ntrap); end
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      step(); redirect_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== 32'h200) begin n_fail++; $display("FAIL trap_resume req=%0b addr=%h want 1/200", mem_req, mem_rd_addr); end
      step(); step(); @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_misaligned !== 1'b0) begin n_fail++; $display("FAIL trap_resume_out v=%0b pc=%h mis=%0b want 1/200/0", out_valid, out_pc, out_misaligned); end
      step();
`else
      do_reset(); out_ready = 1'b1;
      repeat (3) step();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      step(); redirect_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_rd_addr !== 32'h100) begin n_fail++; $display("FAIL align_force req=%0b addr=%h want 1/100", mem_req, mem_rd_addr); end
      step(); step(); @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_misaligned !== 1'b0) begin n_fail++; $display("FAIL align_out v=%0b pc=%h mis=%0b want 1/100/0", out_valid, out_pc, out_misaligned); end
      step();
`endif
   endtask

   // Fetch model: delivered stream is consecutive words from the last reset/redirect target.
   task automatic test_random();
      logic [31:0] exp_out, exp_req, held_pc, held_instr;
      logic held = 1'b0;
      int occ = 0, max_occ = 0;
      do_reset(); exp_out = RPC; exp_req = RPC;
      for (int c = 0; c < 600; c++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = {16'd0, 14'($urandom), 2'b00};
         @(negedge clk);
         if (held) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin n_fail++; $display("FAIL rand_hold c%0d pc=%h want %h", c, out_pc, held_pc); end
         end
         held = out_valid && !out_ready && !redirect_valid;
         held_pc = out_pc; held_instr = out_instr;
         if (out_valid && out_ready) begin
            n_tests++; if (out_pc !== exp_out || out_instr !== mem_word(exp_out)) begin n_fail++; $display("FAIL rand_out c%0d pc=%h instr=%h want %h", c, out_pc, out_instr, exp_out); end
            exp_out += 32'd4; occ--;
         end
         if (redirect_valid) begin
            n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rand_redir_req c%0d got 1 want 0", c); end
            exp_out = redirect_pc; exp_req = redirect_pc; occ = 0;
         end else if (mem_req) begin
            n_tests++; if (mem_rd_addr !== exp_req) begin n_fail++; $display("FAIL rand_req c%0d addr=%h want %h", c, mem_rd_addr, exp_req); end
            exp_req += 32'd4; occ++;
            if (occ > max_occ) max_occ = occ;
         end
         step();
      end
      redirect_valid = 1'b0;
      n_tests++; if (max_occ > DEPTH) begin n_fail++; $display("FAIL rand_credit got %0d outstanding want <=%0d", max_occ, DEPTH); end
   endtask

   initial begin
      step();
      test_reset();
      test_stream();
      test_stall();
      test_redirect_inflight();
      test_redirect_on_transfer();
      test_reset_midstream();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
